// File: rtl/ir_pkg.sv
// Shared types, command bit positions and default timing for the IR packet sequencer.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        GAP      = 3'd2,
        SELECT   = 3'd3,
        RIGHT    = 3'd4,
        LEFT     = 3'd5,
        BACKWARD = 3'd6,
        FORWARD  = 3'd7
    } ir_state_t;

    localparam int CMD_RIGHT    = 3;
    localparam int CMD_LEFT     = 2;
    localparam int CMD_BACKWARD = 1;
    localparam int CMD_FORWARD  = 0;

    localparam int DEF_CARRIER_HALF   = 1389;
    localparam int DEF_START_BURST    = 88;
    localparam int DEF_GAP_LEN        = 40;
    localparam int DEF_SELECT_BURST   = 22;
    localparam int DEF_ASSERT_BURST   = 44;
    localparam int DEF_DEASSERT_BURST = 22;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Every state except IDLE and GAP modulates the LED.
    function automatic logic is_burst(input ir_state_t s);
        logic b;
        case (s)
            START, SELECT, RIGHT, LEFT, BACKWARD, FORWARD: b = 1'b1;
            default:                                       b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier generator. Its outputs describe the clock that follows the next edge,
// so the caller can register LED and packet-end decisions in step with its own next state.
module ir_carrier_gen
    import ir_pkg::*;
#(
    parameter int CARRIER_HALF = DEF_CARRIER_HALF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic restart,
    output logic carrier,
    output logic cycle_end
);

    localparam int HW = $clog2(CARRIER_HALF + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CARRIER_HALF - 1);

    logic [HW-1:0] half_cnt_r;
    logic [HW-1:0] half_cnt_next_s;
    logic          low_half_r;
    logic          low_half_next_s;

    // Phase advance; restart forces the start of a high half.
    always_comb begin
        half_cnt_next_s = half_cnt_r;
        low_half_next_s = low_half_r;
        if (restart) begin
            half_cnt_next_s = '0;
            low_half_next_s = 1'b0;
        end else if (half_cnt_r == HALF_LAST) begin
            half_cnt_next_s = '0;
            low_half_next_s = ~low_half_r;
        end else begin
            half_cnt_next_s = half_cnt_r + HW'(1);
        end
        carrier   = ~low_half_next_s;
        cycle_end = low_half_next_s && (half_cnt_next_s == HALF_LAST);
    end

    // Phase registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            half_cnt_r <= '0;
            low_half_r <= 1'b0;
        end else begin
            half_cnt_r <= half_cnt_next_s;
            low_half_r <= low_half_next_s;
        end
    end

endmodule

// File: rtl/ir_packet_sequencer.sv
// IR command packet sequencer: start, car-select and four command bursts on the carrier.
// Define IR_SEND_QUEUE_EN to hold one request that arrives while a packet is in flight.
module ir_packet_sequencer
    import ir_pkg::*;
#(
    parameter int CARRIER_HALF   = DEF_CARRIER_HALF,
    parameter int START_BURST    = DEF_START_BURST,
    parameter int GAP_LEN        = DEF_GAP_LEN,
    parameter int SELECT_BURST   = DEF_SELECT_BURST,
    parameter int ASSERT_BURST   = DEF_ASSERT_BURST,
    parameter int DEASSERT_BURST = DEF_DEASSERT_BURST
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SEND_PACKET,
    input  logic [3:0] COMMAND,
    output logic       IR_LED,
    output logic       BUSY,
    output logic       PACKET_DONE
);

    localparam int FW = $clog2(max2(max2(START_BURST, GAP_LEN),
                                    max2(max2(SELECT_BURST, ASSERT_BURST), DEASSERT_BURST)) + 1);

    function automatic logic [FW-1:0] cmd_last(input logic bit_set);
        return bit_set ? FW'(ASSERT_BURST - 1) : FW'(DEASSERT_BURST - 1);
    endfunction

    // Final carrier-cycle index of the field held in state s.
    function automatic logic [FW-1:0] last_count(input ir_state_t s, input logic [3:0] cmd);
        logic [FW-1:0] lc;
        case (s)
            START:    lc = FW'(START_BURST - 1);
            GAP:      lc = FW'(GAP_LEN - 1);
            SELECT:   lc = FW'(SELECT_BURST - 1);
            RIGHT:    lc = cmd_last(cmd[CMD_RIGHT]);
            LEFT:     lc = cmd_last(cmd[CMD_LEFT]);
            BACKWARD: lc = cmd_last(cmd[CMD_BACKWARD]);
            FORWARD:  lc = cmd_last(cmd[CMD_FORWARD]);
            default:  lc = '0;
        endcase
        return lc;
    endfunction

    ir_state_t     state_r, state_next_s;
    ir_state_t     next_field_r, next_field_next_s;
    logic [FW-1:0] field_cnt_r, field_cnt_next_s;
    logic [3:0]    cmd_q_r, cmd_q_next_s;
    logic          cyc_end_r;
    logic          busy_r, done_r, led_r;
    logic          busy_next_s, done_next_s, led_next_s;
    logic          restart_s, carrier_s, cyc_end_s;
`ifdef IR_SEND_QUEUE_EN
    logic          pend_r, pend_next_s;
`endif

    ir_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
        .CLK       (CLK),
        .RESET     (RESET),
        .restart   (restart_s),
        .carrier   (carrier_s),
        .cycle_end (cyc_end_s)
    );

    // Field sequencing plus look-ahead of the registered outputs.
    always_comb begin
        state_next_s      = state_r;
        next_field_next_s = next_field_r;
        field_cnt_next_s  = field_cnt_r;
        cmd_q_next_s      = cmd_q_r;
        restart_s         = 1'b0;
`ifdef IR_SEND_QUEUE_EN
        pend_next_s       = pend_r || ((state_r != IDLE) && SEND_PACKET);
`endif
        if (state_r == IDLE) begin
            if (SEND_PACKET) begin
                state_next_s     = START;
                field_cnt_next_s = '0;
                cmd_q_next_s     = COMMAND;
                restart_s        = 1'b1;
            end else begin
                state_next_s = IDLE;
            end
        end else if (cyc_end_r && (field_cnt_r == last_count(state_r, cmd_q_r))) begin
            field_cnt_next_s = '0;
            case (state_r)
                START:    begin state_next_s = GAP; next_field_next_s = SELECT;   end
                GAP:      begin state_next_s = next_field_r;                      end
                SELECT:   begin state_next_s = GAP; next_field_next_s = RIGHT;    end
                RIGHT:    begin state_next_s = GAP; next_field_next_s = LEFT;     end
                LEFT:     begin state_next_s = GAP; next_field_next_s = BACKWARD; end
                BACKWARD: begin state_next_s = GAP; next_field_next_s = FORWARD;  end
                FORWARD: begin
`ifdef IR_SEND_QUEUE_EN
                    // A held request starts back-to-back with COMMAND sampled now.
                    if (pend_next_s) begin
                        state_next_s = START;
                        cmd_q_next_s = COMMAND;
                        restart_s    = 1'b1;
                        pend_next_s  = 1'b0;
                    end else begin
                        state_next_s = IDLE;
                    end
`else
                    state_next_s = IDLE;
`endif
                end
                default:  begin state_next_s = IDLE; end
            endcase
        end else if (cyc_end_r) begin
            field_cnt_next_s = field_cnt_r + FW'(1);
        end else begin
            field_cnt_next_s = field_cnt_r;
        end

        busy_next_s = (state_next_s != IDLE);
        led_next_s  = carrier_s && is_burst(state_next_s);
        done_next_s = (state_next_s == FORWARD) && cyc_end_s &&
                      (field_cnt_next_s == last_count(state_next_s, cmd_q_next_s));
    end

    // State, counters and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= IDLE;
            next_field_r <= IDLE;
            field_cnt_r  <= '0;
            cmd_q_r      <= 4'd0;
            cyc_end_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            led_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            next_field_r <= next_field_next_s;
            field_cnt_r  <= field_cnt_next_s;
            cmd_q_r      <= cmd_q_next_s;
            cyc_end_r    <= cyc_end_s;
            busy_r       <= busy_next_s;
            done_r       <= done_next_s;
            led_r        <= led_next_s;
        end
    end

`ifdef IR_SEND_QUEUE_EN
    // Pending-request flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_next_s;
        end
    end
`endif

    assign IR_LED      = led_r;
    assign BUSY        = busy_r;
    assign PACKET_DONE = done_r;

endmodule

// File: tb/tb_ir_packet_sequencer.sv
// Randomised bench for ir_packet_sequencer against a per-clock waveform model built from packet rules.
module tb_ir_packet_sequencer;

    localparam int H  = 2;
    localparam int SB = 4;
    localparam int GL = 2;
    localparam int SL = 2;
    localparam int AB = 3;
    localparam int DB = 1;

    logic       CLK;
    logic       RESET;
    logic       SEND_PACKET;
    logic [3:0] COMMAND;
    logic       IR_LED;
    logic       BUSY;
    logic       PACKET_DONE;

    int total;
    int bad;
    int obs_busy;
    int obs_led;
    int obs_done;
    int obs_done_at;

    // Expected {BUSY, IR_LED, PACKET_DONE} per clock; front is the current clock.
    logic [2:0] exp_q[$];
    bit         pend_m;

    ir_packet_sequencer #(
        .CARRIER_HALF   (H),
        .START_BURST    (SB),
        .GAP_LEN        (GL),
        .SELECT_BURST   (SL),
        .ASSERT_BURST   (AB),
        .DEASSERT_BURST (DB)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SEND_PACKET (SEND_PACKET),
        .COMMAND     (COMMAND),
        .IR_LED      (IR_LED),
        .BUSY        (BUSY),
        .PACKET_DONE (PACKET_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, got, want);
        end
    endtask

    function automatic void push_packet(input logic [3:0] c);
        int         len [11];
        bit         bst [11];
        logic [2:0] tail;
        len = '{SB, GL, SL, GL, (c[3] ? AB : DB), GL, (c[2] ? AB : DB), GL,
                (c[1] ? AB : DB), GL, (c[0] ? AB : DB)};
        bst = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int f = 0; f < 11; f++) begin
            for (int t = 0; t < len[f] * 2 * H; t++) begin
                exp_q.push_back({1'b1, (bst[f] && ((t % (2 * H)) < H)), 1'b0});
            end
        end
        tail = exp_q.pop_back();
        exp_q.push_back(tail | 3'b001);
    endfunction

    function automatic void model_step(input logic send, input logic [3:0] cmd);
        if (exp_q.size() > 0) begin
`ifdef IR_SEND_QUEUE_EN
            if (send) pend_m = 1'b1;
`endif
            exp_q.delete(0);
`ifdef IR_SEND_QUEUE_EN
            if ((exp_q.size() == 0) && pend_m) begin
                push_packet(cmd);
                pend_m = 1'b0;
            end
`endif
        end else if (send) begin
            push_packet(cmd);
        end
    endfunction

    task automatic clear_obs();
        obs_busy    = 0;
        obs_led     = 0;
        obs_done    = 0;
        obs_done_at = 0;
    endtask

    task automatic tick(input logic send, input logic [3:0] cmd);
        logic [2:0] e;
        @(negedge CLK);
        e = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
        check_val("outputs", {29'd0, BUSY, IR_LED, PACKET_DONE}, {29'd0, e});
        if (BUSY === 1'b1) obs_busy++;
        if (IR_LED === 1'b1) obs_led++;
        if (PACKET_DONE === 1'b1) begin
            obs_done++;
            obs_done_at = obs_busy;
        end
        SEND_PACKET = send;
        COMMAND     = cmd;
        @(posedge CLK);
        model_step(send, cmd);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        pend_m      = 1'b0;
        RESET       = 1'b0;
        SEND_PACKET = 1'b0;
        COMMAND     = 4'd0;
        clear_obs();
        #2 RESET = 1'b1;
        @(negedge CLK);
        check_val("reset_state", {29'd0, BUSY, IR_LED, PACKET_DONE}, 32'd0);
        RESET = 1'b0;
        repeat (3) tick(1'b0, 4'd0);

        // Basic packet with COMMAND scrambled after acceptance.
        clear_obs();
        tick(1'b1, 4'b0101);
        repeat (110) tick(1'b0, 4'($urandom));
        check_val("basic_busy_len", obs_busy, 32'd96);
        check_val("basic_led_clks", obs_led, 32'd28);
        check_val("basic_done_cnt", obs_done, 32'd1);
        check_val("basic_done_at", obs_done_at, 32'd96);

        clear_obs();
        tick(1'b1, 4'b1111);
        repeat (120) tick(1'b0, 4'($urandom));
        check_val("all_busy_len", obs_busy, 32'd112);

        clear_obs();
        tick(1'b1, 4'b0001);
        for (int i = 1; i <= 105; i++) tick(1'b0, (i >= 10) ? 4'b1110 : 4'b0001);
        check_val("midchg_busy_len", obs_busy, 32'd88);

        // Request arriving at clock 50 of a packet.
        clear_obs();
        tick(1'b1, 4'b0101);
        for (int i = 1; i <= 215; i++) tick(i == 50, 4'b0101);
`ifdef IR_SEND_QUEUE_EN
        check_val("busyreq_busy_len", obs_busy, 32'd192);
        check_val("busyreq_done_cnt", obs_done, 32'd2);
        check_val("busyreq_done_at", obs_done_at, 32'd192);
`else
        check_val("busyreq_busy_len", obs_busy, 32'd96);
        check_val("busyreq_done_cnt", obs_done, 32'd1);
        check_val("busyreq_done_at", obs_done_at, 32'd96);
`endif

        // Asynchronous reset during clock 30 of a packet.
        tick(1'b1, 4'b0101);
        repeat (29) tick(1'b0, 4'b0101);
        #2 RESET = 1'b1;
        #1;
        check_val("rst_busy", {31'd0, BUSY}, 32'd0);
        check_val("rst_led", {31'd0, IR_LED}, 32'd0);
        exp_q.delete();
        pend_m = 1'b0;
        @(negedge CLK);
        check_val("rst_hold", {29'd0, BUSY, IR_LED, PACKET_DONE}, 32'd0);
        RESET = 1'b0;
        repeat (3) tick(1'b0, 4'd0);
        clear_obs();
        tick(1'b1, 4'b0101);
        repeat (110) tick(1'b0, 4'($urandom));
        check_val("after_rst_busy_len", obs_busy, 32'd96);
        check_val("after_rst_done_cnt", obs_done, 32'd1);

        repeat (3000) tick(($urandom_range(0, 29) == 0), 4'($urandom));
        repeat (250) tick(1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
